// File: rtl/wm8731_pkg.sv
// wm8731_pkg: shared definitions for the WM8731 control-port responder.
//   - register index constants for the ten WM8731 registers and the reset register
//   - power-on default values of the register file
//   - FSM state encoding for the I2C write-frame receiver
package wm8731_pkg;

  localparam logic [6:0] R_LINVOL = 7'h00;  // left line in
  localparam logic [6:0] R_RINVOL = 7'h01;  // right line in
  localparam logic [6:0] R_LHPOUT = 7'h02;  // left headphone out
  localparam logic [6:0] R_RHPOUT = 7'h03;  // right headphone out
  localparam logic [6:0] R_APANA  = 7'h04;  // analogue audio path
  localparam logic [6:0] R_DPATH  = 7'h05;  // digital audio path
  localparam logic [6:0] R_PWR    = 7'h06;  // power down control
  localparam logic [6:0] R_IFACE  = 7'h07;  // digital audio interface format
  localparam logic [6:0] R_SRATE  = 7'h08;  // sampling control
  localparam logic [6:0] R_ACTIVE = 7'h09;  // active control
  localparam logic [6:0] R_RESET  = 7'h0F;  // writing any value restores defaults

  localparam int NUM_REGS = 10;

  localparam logic [8:0] REG_DEFAULTS [NUM_REGS] = '{
    9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
    9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_A,
    ST_BYTE_H,
    ST_ACK_H,
    ST_BYTE_L,
    ST_ACK_L,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: brings the asynchronous SCL/SDA pins into the clock domain
// and derives bus events from the synchronized levels.
//   clk, rst_n          : clock, synchronous active-low reset
//   scl_in, sda_in      : raw bus pins
//   scl_rise, scl_fall  : single-cycle SCL edge indications
//   start_det, stop_det : SDA falling / rising while SCL is stably high
//   sda_s               : synchronized SDA level (data bit value)
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync_reg;
  logic [SYNC_STAGES-1:0] sda_sync_reg;
  logic                   scl_d_reg;
  logic                   sda_d_reg;
  logic                   scl_s;

  // Presetting to 1 makes the idle bus look released, so reset never
  // produces a phantom START or edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_d_reg    <= 1'b1;
      sda_d_reg    <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_in};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_in};
      scl_d_reg    <= scl_sync_reg[SYNC_STAGES-1];
      sda_d_reg    <= sda_sync_reg[SYNC_STAGES-1];
    end
  end

  assign scl_s = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s = sda_sync_reg[SYNC_STAGES-1];

  assign scl_rise  = scl_s & ~scl_d_reg;
  assign scl_fall  = ~scl_s & scl_d_reg;
  // SCL must be high in both samples so an SDA change coinciding with an
  // SCL edge is never mistaken for a bus condition.
  assign start_det = scl_s & scl_d_reg & sda_d_reg & ~sda_s;
  assign stop_det  = scl_s & scl_d_reg & ~sda_d_reg & sda_s;

endmodule

// File: rtl/wm8731_i2c_responder.sv
// wm8731_i2c_responder: I2C write-only target modelling the WM8731 control port.
// Receives {dev_addr,W}, {reg[6:0],data[8]}, data[7:0]; ACKs each byte and
// commits the 9-bit value into a WM8731-shaped register file.
//   sys_clk50MHz, sys_rst_n : clock, synchronous active-low reset
//   scl_in, sda_in          : bus pins (asynchronous)
//   sda_oe                  : 1 = pull SDA low
//   wr_valid/wr_addr/wr_data: one-cycle strobe of each committed write
//   rd_addr/rd_data         : combinational register read (0 above R9)
//   busy                    : frame in progress (START seen, no STOP yet)
//   frame_err               : one-cycle pulse on aborted/unaddressed frame
import wm8731_pkg::*;

module wm8731_i2c_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       sys_clk50MHz,
  input  logic       sys_rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       busy,
  output logic       frame_err
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk       (sys_clk50MHz),
    .rst_n     (sys_rst_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] byte_h_reg, byte_h_next;
  logic       sda_oe_reg, sda_oe_next;
  logic       wr_valid_reg, wr_valid_next;
  logic       frame_err_reg, frame_err_next;
  logic [6:0] wr_addr_reg, wr_addr_next;
  logic [8:0] wr_data_reg, wr_data_next;
  logic       commit;
  logic [7:0] byte_in;
  logic       aborting;
  logic [8:0] reg_file [NUM_REGS];

  assign byte_in = {shift_reg[6:0], sda_s};

  // A frame is still uncommitted until ACK_L has driven its ACK; ending it
  // earlier (START/STOP) counts as an abort. IGNORE already reported or
  // already committed, so it never reports again.
  assign aborting = (state_reg != ST_IDLE) && (state_reg != ST_IGNORE) &&
                    !((state_reg == ST_ACK_L) && sda_oe_reg);

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    byte_h_next    = byte_h_reg;
    sda_oe_next    = sda_oe_reg;
    wr_valid_next  = 1'b0;
    frame_err_next = 1'b0;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    commit         = 1'b0;
    if (start_det) begin
      frame_err_next = aborting;
      state_next     = ST_ADDR;
      bit_cnt_next   = 3'd0;
      sda_oe_next    = 1'b0;
    end else if (stop_det) begin
      frame_err_next = aborting;
      state_next     = ST_IDLE;
      bit_cnt_next   = 3'd0;
      sda_oe_next    = 1'b0;
    end else begin
      case (state_reg)
        ST_ADDR, ST_BYTE_H, ST_BYTE_L: begin
          if (scl_rise) begin
            shift_next   = byte_in;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              if (state_reg == ST_ADDR) begin
                // Only a write to our address is acknowledged.
                if (byte_in == {DEV_ADDR, 1'b0}) begin
                  state_next = ST_ACK_A;
                end else begin
                  state_next     = ST_IGNORE;
                  frame_err_next = 1'b1;
                end
              end else if (state_reg == ST_BYTE_H) begin
                byte_h_next = byte_in;
                state_next  = ST_ACK_H;
              end else begin
                state_next = ST_ACK_L;
              end
            end
          end
        end
        ST_ACK_A, ST_ACK_H, ST_ACK_L: begin
          // First SCL fall after the 8th bit grabs SDA; the next fall
          // (end of the 9th clock) lets it go.
          if (scl_fall) begin
            if (!sda_oe_reg) begin
              sda_oe_next = 1'b1;
              if (state_reg == ST_ACK_L) begin
                commit        = 1'b1;
                wr_valid_next = 1'b1;
                wr_addr_next  = byte_h_reg[7:1];
                wr_data_next  = {byte_h_reg[0], shift_reg};
              end
            end else begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = 3'd0;
              case (state_reg)
                ST_ACK_A: state_next = ST_BYTE_H;
                ST_ACK_H: state_next = ST_BYTE_L;
                default:  state_next = ST_IGNORE;
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk50MHz) begin
    if (!sys_rst_n) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 8'd0;
      byte_h_reg    <= 8'd0;
      sda_oe_reg    <= 1'b0;
      wr_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      wr_addr_reg   <= 7'd0;
      wr_data_reg   <= 9'd0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      byte_h_reg    <= byte_h_next;
      sda_oe_reg    <= sda_oe_next;
      wr_valid_reg  <= wr_valid_next;
      frame_err_reg <= frame_err_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
    end
  end

  // One register per generate slice; writing R_RESET reloads every slice.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [8:0] value_reg;
    always_ff @(posedge sys_clk50MHz) begin
      if (!sys_rst_n || (commit && (wr_addr_next == R_RESET))) begin
        value_reg <= REG_DEFAULTS[gi];
      end else if (commit && (wr_addr_next == 7'(gi))) begin
        value_reg <= wr_data_next;
      end
    end
    assign reg_file[gi] = value_reg;
  end

  always_comb begin
    rd_data = 9'd0;
    if (rd_addr < 4'd10) begin
      rd_data = reg_file[rd_addr];
    end
  end

  assign sda_oe    = sda_oe_reg;
  assign wr_valid  = wr_valid_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;
  assign frame_err = frame_err_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_wm8731_i2c_responder.sv
// Testbench for wm8731_i2c_responder: bit-banged I2C master, register-file
// reference model and a write scoreboard checked by an independent monitor.
module tb_wm8731_i2c_responder;

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_in, sda_in;
  logic       sda_oe, wr_valid, busy, frame_err;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic [3:0] rd_addr;
  logic [8:0] rd_data;

  always #10 clk = ~clk;

  // Open-drain bus: the target can only pull SDA low.
  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  wm8731_i2c_responder dut (
    .sys_clk50MHz (clk),
    .sys_rst_n    (sys_rst_n),
    .scl_in       (scl_in),
    .sda_in       (sda_in),
    .sda_oe       (sda_oe),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy),
    .frame_err    (frame_err)
  );

  localparam int Q = 8;  // clocks per quarter SCL period (scaled-up bus rate)

  typedef struct {
    logic [6:0] a;
    logic [8:0] d;
  } wr_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   err_seen = 0;
  int   err_exp = 0;
  wr_t  exp_q[$];
  wr_t  mon_e;
  logic [8:0] DEF [10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                           9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
  logic [8:0] model [10];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a write.
  always @(negedge clk) begin
    if (sys_rst_n === 1'b1) begin
      if (frame_err) err_seen++;
      if (wr_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL wr_unexpected: got addr %0h data %0h, required no write", wr_addr, wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (wr_addr !== mon_e.a || wr_data !== mon_e.d) begin
            miscompares++;
            $display("FAIL wr_txn: got addr %0h data %0h, required addr %0h data %0h",
                     wr_addr, wr_data, mon_e.a, mon_e.d);
          end else begin
            $display("write addr=%0h data=%03h", wr_addr, wr_data);
          end
        end
      end
    end
  end

  initial begin
    #(20 * 200000);
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic model_write(input logic [6:0] a, input logic [8:0] d);
    if (a < 7'd10) model[a] = d;
    else if (a == 7'h0F) model = DEF;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; wait_q(1);
    sda_m = 1'b0; wait_q(1);
    scl_m = 1'b0;
  endtask

  task automatic i2c_rstart();
    wait_q(1); sda_m = 1'b1;
    wait_q(1); scl_m = 1'b1;
    wait_q(1); sda_m = 1'b0;
    wait_q(1); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_q(1); sda_m = 1'b0;
    wait_q(1); scl_m = 1'b1;
    wait_q(1); sda_m = 1'b1;
    wait_q(2);
  endtask

  // Sends nbits of b MSB first; a full byte is followed by the ACK clock.
  task automatic send_byte(input logic [7:0] b, input bit exp_ack, input int nbits);
    for (int i = 7; i >= 8 - nbits; i--) begin
      wait_q(1); sda_m = b[i];
      wait_q(1); scl_m = 1'b1;
      wait_q(2); scl_m = 1'b0;
    end
    if (nbits == 8) begin
      wait_q(1); sda_m = 1'b1;
      wait_q(1); scl_m = 1'b1;
      wait_q(1); check("ack", sda_oe, exp_ack);
      wait_q(1); scl_m = 1'b0;
      wait_q(1); check("ack_release", sda_oe, 0);
    end
  endtask

  task automatic check_regs();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd_addr = 4'(i);
      #1;
      check($sformatf("rd_R%0d", i), rd_data, (i < 10) ? int'(model[i]) : 0);
    end
  endtask

  task automatic do_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    bit         ok = (b0 == 8'h34);
    logic [6:0] ra = b1[7:1];
    logic [8:0] d  = {b1[0], b2};
    wr_t        e;
    e.a = ra; e.d = d;
    if (ok) exp_q.push_back(e);
    else err_exp++;
    i2c_start();
    send_byte(b0, ok, 8);
    send_byte(b1, ok, 8);
    send_byte(b2, ok, 8);
    check("busy_mid", busy, 1);
    i2c_stop();
    if (ok) model_write(ra, d);
    check("frame_err_count", err_seen, err_exp);
    check("busy_after_stop", busy, 0);
    check("wr_drained", exp_q.size(), 0);
    $display("frame %02h %02h %02h acked=%0d", b0, b1, b2, ok);
  endtask

  initial begin
    logic [7:0] b0;
    logic [6:0] r;
    logic [8:0] d;
    sys_rst_n = 1'b0;
    rd_addr   = 4'd0;
    repeat (4) @(negedge clk);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    sys_rst_n = 1'b1;
    model = DEF;
    repeat (4) @(negedge clk);
    check_regs();

    do_frame(8'h34, 8'h08, 8'h12); check_regs();   // R4 = 0x012
    do_frame(8'h34, 8'h0D, 8'hFF); check_regs();   // R6 = 0x1FF
    do_frame(8'hAA, 8'h3C, 8'hC3); check_regs();   // wrong address
    do_frame(8'h34, 8'h08, 8'h12);
    do_frame(8'h34, 8'h1E, 8'h00); check_regs();   // reset register

    // Repeated START drops a partial frame, then a full frame to R7.
    err_exp++;
    mon_e.a = 7'd7; mon_e.d = 9'h04A; exp_q.push_back(mon_e);
    i2c_start();
    send_byte(8'h34, 1, 8);
    send_byte(8'h0E, 1, 8);
    i2c_rstart();
    send_byte(8'h34, 1, 8);
    send_byte(8'h0E, 1, 8);
    send_byte(8'h4A, 1, 8);
    i2c_stop();
    model_write(7'd7, 9'h04A);
    check("rstart_err_count", err_seen, err_exp);
    check("rstart_drained", exp_q.size(), 0);
    $display("frame 34 0E <Sr> 34 0E 4A");
    check_regs();

    // Reset in the middle of the low data byte.
    do_frame(8'h34, 8'h0A, 8'h55);
    i2c_start();
    send_byte(8'h34, 1, 8);
    send_byte(8'h08, 1, 8);
    send_byte(8'h12, 0, 4);
    sys_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_sda_oe", sda_oe, 0);
    check("midrst_busy", busy, 0);
    check("midrst_wr_valid", wr_valid, 0);
    sys_rst_n = 1'b1;
    model = DEF;
    i2c_stop();
    check("midrst_busy_after", busy, 0);
    $display("frame 34 08 <reset during low byte>");
    check_regs();
    do_frame(8'h34, 8'h0A, 8'h55); check_regs();

    // Random frames: mostly to our address, any register 0-15.
    repeat (20) begin
      r  = 7'($urandom_range(0, 15));
      d  = 9'($urandom_range(0, 511));
      b0 = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'h34;
      do_frame(b0, {r, d[8]}, d[7:0]);
      check_regs();
    end

    check("final_err_count", err_seen, err_exp);
    check("final_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
